// File: rtl/pong_pkg.sv
// Shared types and defaults for the pong XY display pipeline.
package pong_pkg;

  localparam int COORD_W    = 8;
  localparam int Y_MAX      = 220;
  localparam int PARK_X_DEF = 128;
  localparam int PARK_Y_DEF = 110;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DRAW   = 2'd2
  } sched_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/xy_beam_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, modulo N.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          valid,
  output logic [PW-1:0] winner
);

  // Scan from the farthest candidate back to ptr so the closest requester is assigned last
  always_comb begin
    int idx;
    idx    = 0;
    valid  = 1'b0;
    winner = {PW{1'b0}};
    for (int k = N - 1; k >= 0; k--) begin
      idx    = (int'(ptr) + k) % N;
      valid  = valid | req[idx];
      winner = req[idx] ? PW'(idx) : winner;
    end
  end

endmodule

// File: rtl/xy_beam_scheduler.sv
// Round-robin time-multiplexer of one XY DAC across N_SRC point streams with blanked settle.
// Optional frame counter outputs are built when SCHED_FRAME_SYNC_EN is defined.
module xy_beam_scheduler
  import pong_pkg::*;
#(
  parameter int N_SRC  = 4,
  parameter int W      = COORD_W,
  parameter int DWELL  = 64,
  parameter int SETTLE = 4,
  parameter int PARK_X = PARK_X_DEF,
  parameter int PARK_Y = PARK_Y_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_SRC-1:0]   src_req,
  input  logic [N_SRC*W-1:0] src_x,
  input  logic [N_SRC*W-1:0] src_y,
  output logic [N_SRC-1:0]   src_grant,
  output logic [N_SRC-1:0]   src_adv,
  output logic [W-1:0]       dac_x,
  output logic [W-1:0]       dac_y,
  output logic               blank,
  output logic               slot_start
`ifdef SCHED_FRAME_SYNC_EN
  ,
  output logic               frame_sync,
  output logic [7:0]         frame_cnt
`endif
);

  localparam int PW    = $clog2(N_SRC);
  localparam int CNT_W = $clog2(max_int(DWELL, SETTLE)) + 1;
  localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE > 0) ? (SETTLE - 1) : 0);

  sched_state_e      state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d, owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_SRC-1:0]  grant_q, grant_d, adv_q, adv_d;
  logic [W-1:0]      dac_x_q, dac_x_d, dac_y_q, dac_y_d;
  logic              blank_q, blank_d, slot_start_q, slot_start_d;

  logic              arb_valid_s, slot_end_s, do_grant_s, stay_s;
  logic [PW-1:0]     arb_winner_s, ptr_nxt_s;
  logic [N_SRC-1:0]  win_oh_s;
  logic [W-1:0]      own_x_s, own_y_s;

  rr_arbiter #(.N(N_SRC)) u_arb (
    .req    (src_req),
    .ptr    (ptr_q),
    .valid  (arb_valid_s),
    .winner (arb_winner_s)
  );

  assign own_x_s   = src_x[int'(owner_q)*W +: W];
  assign own_y_s   = src_y[int'(owner_q)*W +: W];
  assign win_oh_s  = {{(N_SRC-1){1'b0}}, 1'b1} << arb_winner_s;
  assign ptr_nxt_s = (arb_winner_s == PW'(N_SRC - 1)) ? {PW{1'b0}} : (arb_winner_s + PW'(1));
  // Re-granting the current owner keeps the beam in place, so no settle is needed
  assign stay_s    = (state_q == ST_DRAW) && (arb_winner_s == owner_q);

  // Next-state, slot accounting and next-output computation
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    adv_d        = {N_SRC{1'b0}};
    dac_x_d      = dac_x_q;
    dac_y_d      = dac_y_q;
    blank_d      = blank_q;
    slot_start_d = 1'b0;
    slot_end_s   = 1'b0;
    do_grant_s   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        blank_d    = 1'b1;
        grant_d    = {N_SRC{1'b0}};
        do_grant_s = arb_valid_s;
      end
      ST_SETTLE: begin
        dac_x_d = own_x_s;
        dac_y_d = own_y_s;
        if (cnt_q == SETTLE_LAST) begin
          state_d      = ST_DRAW;
          cnt_d        = {CNT_W{1'b0}};
          blank_d      = 1'b0;
          adv_d        = grant_q;
          slot_start_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DRAW: begin
        // A dropped request discards this cycle's point and ends the slot
        if (!src_req[owner_q]) begin
          slot_end_s = 1'b1;
        end else begin
          dac_x_d = own_x_s;
          dac_y_d = own_y_s;
          if (cnt_q == DWELL_LAST) begin
            slot_end_s = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            adv_d = grant_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = {N_SRC{1'b0}};
        blank_d = 1'b1;
      end
    endcase

    if (slot_end_s) begin
      cnt_d      = {CNT_W{1'b0}};
      do_grant_s = arb_valid_s;
      if (!arb_valid_s) begin
        state_d = ST_IDLE;
        grant_d = {N_SRC{1'b0}};
        blank_d = 1'b1;
      end else begin
        state_d = state_q;
      end
    end else begin
      state_d = state_d;
    end

    if (do_grant_s) begin
      owner_d = arb_winner_s;
      ptr_d   = ptr_nxt_s;
      grant_d = win_oh_s;
      cnt_d   = {CNT_W{1'b0}};
      if ((SETTLE > 0) && !stay_s) begin
        state_d = ST_SETTLE;
        blank_d = 1'b1;
        adv_d   = {N_SRC{1'b0}};
      end else begin
        state_d      = ST_DRAW;
        blank_d      = 1'b0;
        adv_d        = win_oh_s;
        slot_start_d = 1'b1;
      end
    end else begin
      owner_d = owner_q;
    end
  end

  // Scheduler state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= {PW{1'b0}};
      owner_q      <= {PW{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
      grant_q      <= {N_SRC{1'b0}};
      adv_q        <= {N_SRC{1'b0}};
      dac_x_q      <= W'(PARK_X);
      dac_y_q      <= W'(PARK_Y);
      blank_q      <= 1'b1;
      slot_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      adv_q        <= adv_d;
      dac_x_q      <= dac_x_d;
      dac_y_q      <= dac_y_d;
      blank_q      <= blank_d;
      slot_start_q <= slot_start_d;
    end
  end

  assign src_grant  = grant_q;
  assign src_adv    = adv_q;
  assign dac_x      = dac_x_q;
  assign dac_y      = dac_y_q;
  assign blank      = blank_q;
  assign slot_start = slot_start_q;

`ifdef SCHED_FRAME_SYNC_EN
  logic       frame_sync_q, frame_sync_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;

  // A grant whose new pointer is not ahead of the old one has wrapped past the last source
  always_comb begin
    frame_sync_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    if (do_grant_s && (ptr_nxt_s <= ptr_q)) begin
      frame_sync_d = 1'b1;
      frame_cnt_d  = frame_cnt_q + 8'd1;
    end else begin
      frame_cnt_d  = frame_cnt_q;
    end
  end

  // Frame marker registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_sync_q <= 1'b0;
      frame_cnt_q  <= 8'd0;
    end else begin
      frame_sync_q <= frame_sync_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign frame_sync = frame_sync_q;
  assign frame_cnt  = frame_cnt_q;
`endif

endmodule

// File: tb/tb_xy_beam_scheduler.sv
// Bench: two schedulers (SETTLE=2/DWELL=4 and SETTLE=0/DWELL=3) share random stimulus
// and are compared each cycle against a slot-level reference model.
module tb_xy_beam_scheduler;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   src_req;
  logic [N*W-1:0] src_x, src_y;

  logic [N-1:0] g0, a0, g1, a1;
  logic [W-1:0] x0, y0, x1, y1;
  logic         b0, ss0, b1, ss1;
`ifdef SCHED_FRAME_SYNC_EN
  logic         fs0, fs1;
  logic [7:0]   fc0, fc1;
`endif

  always #5 clk = ~clk;

  xy_beam_scheduler #(.N_SRC(N), .W(W), .DWELL(4), .SETTLE(2), .PARK_X(128), .PARK_Y(110)) u0 (
    .clk(clk), .rst_n(rst_n), .src_req(src_req), .src_x(src_x), .src_y(src_y),
    .src_grant(g0), .src_adv(a0), .dac_x(x0), .dac_y(y0), .blank(b0), .slot_start(ss0)
`ifdef SCHED_FRAME_SYNC_EN
    , .frame_sync(fs0), .frame_cnt(fc0)
`endif
  );

  xy_beam_scheduler #(.N_SRC(N), .W(W), .DWELL(3), .SETTLE(0), .PARK_X(128), .PARK_Y(110)) u1 (
    .clk(clk), .rst_n(rst_n), .src_req(src_req), .src_x(src_x), .src_y(src_y),
    .src_grant(g1), .src_adv(a1), .dac_x(x1), .dac_y(y1), .blank(b1), .slot_start(ss1)
`ifdef SCHED_FRAME_SYNC_EN
    , .frame_sync(fs1), .frame_cnt(fc1)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 settle, 2 draw; m_left counts remaining cycles of the phase
  int         m_phase[2], m_owner[2], m_ptr[2], m_left[2], m_fcnt[2];
  logic [3:0] e_grant[2], e_adv[2];
  logic [7:0] e_x[2], e_y[2];
  logic       e_blank[2], e_ss[2], e_fs[2];

  function automatic int dwell_of(input int u);
    return (u == 0) ? 4 : 3;
  endfunction

  function automatic int settle_of(input int u);
    return (u == 0) ? 2 : 0;
  endfunction

  function automatic int pick(input logic [3:0] req, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic m_reset(input int u);
    m_phase[u] = 0; m_owner[u] = 0; m_ptr[u] = 0; m_left[u] = 0; m_fcnt[u] = 0;
    e_grant[u] = 4'd0; e_adv[u] = 4'd0; e_x[u] = 8'd128; e_y[u] = 8'd110;
    e_blank[u] = 1'b1; e_ss[u] = 1'b0; e_fs[u] = 1'b0;
  endtask

  task automatic m_grant(input int u, input int w);
    if (((w + 1) % N) <= m_ptr[u]) begin
      m_fcnt[u] = (m_fcnt[u] + 1) % 256;
      e_fs[u]   = 1'b1;
    end
    m_ptr[u]   = (w + 1) % N;
    m_owner[u] = w;
    e_grant[u] = 4'(1) << w;
  endtask

  task automatic m_draw(input int u);
    m_phase[u] = 2; m_left[u] = dwell_of(u);
    e_blank[u] = 1'b0; e_adv[u] = e_grant[u]; e_ss[u] = 1'b1;
  endtask

  task automatic m_after_grant(input int u, input bit same);
    if (!same && settle_of(u) > 0) begin
      m_phase[u] = 1; m_left[u] = settle_of(u);
      e_blank[u] = 1'b1; e_adv[u] = 4'd0;
    end else begin
      m_draw(u);
    end
  endtask

  task automatic m_end(input int u);
    int w;
    bit same;
    w = pick(src_req, m_ptr[u]);
    if (w < 0) begin
      m_phase[u] = 0; e_grant[u] = 4'd0; e_blank[u] = 1'b1; e_adv[u] = 4'd0;
    end else begin
      same = (w == m_owner[u]);
      m_grant(u, w);
      m_after_grant(u, same);
    end
  endtask

  task automatic m_step(input int u);
    int w;
    e_ss[u] = 1'b0; e_fs[u] = 1'b0; e_adv[u] = 4'd0;
    case (m_phase[u])
      0: begin
        w = pick(src_req, m_ptr[u]);
        if (w >= 0) begin
          m_grant(u, w);
          m_after_grant(u, 1'b0);
        end
      end
      1: begin
        e_x[u] = src_x[m_owner[u]*W +: W];
        e_y[u] = src_y[m_owner[u]*W +: W];
        m_left[u]--;
        if (m_left[u] == 0) m_draw(u);
      end
      default: begin
        if (!src_req[m_owner[u]]) begin
          m_end(u);
        end else begin
          e_x[u] = src_x[m_owner[u]*W +: W];
          e_y[u] = src_y[m_owner[u]*W +: W];
          m_left[u]--;
          if (m_left[u] == 0) m_end(u);
          else e_adv[u] = e_grant[u];
        end
      end
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reset(0);
      m_reset(1);
    end else begin
      m_step(0);
      m_step(1);
    end
  end

  task automatic check_all();
    check_val("grant0", 32'(g0), 32'(e_grant[0]));
    check_val("adv0",   32'(a0), 32'(e_adv[0]));
    check_val("dacx0",  32'(x0), 32'(e_x[0]));
    check_val("dacy0",  32'(y0), 32'(e_y[0]));
    check_val("blank0", 32'(b0), 32'(e_blank[0]));
    check_val("slot0",  32'(ss0), 32'(e_ss[0]));
    check_val("grant1", 32'(g1), 32'(e_grant[1]));
    check_val("adv1",   32'(a1), 32'(e_adv[1]));
    check_val("dacx1",  32'(x1), 32'(e_x[1]));
    check_val("dacy1",  32'(y1), 32'(e_y[1]));
    check_val("blank1", 32'(b1), 32'(e_blank[1]));
    check_val("slot1",  32'(ss1), 32'(e_ss[1]));
`ifdef SCHED_FRAME_SYNC_EN
    check_val("fsync0", 32'(fs0), 32'(e_fs[0]));
    check_val("fcnt0",  32'(fc0), 32'(m_fcnt[0]));
    check_val("fsync1", 32'(fs1), 32'(e_fs[1]));
    check_val("fcnt1",  32'(fc1), 32'(m_fcnt[1]));
`endif
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    src_x = $urandom;
    src_y = $urandom;
  endtask

  task automatic check_parked(input string tag);
    check_val({tag, "_blank0"}, 32'(b0), 32'd1);
    check_val({tag, "_x0"},     32'(x0), 32'd128);
    check_val({tag, "_y0"},     32'(y0), 32'd110);
    check_val({tag, "_grant0"}, 32'(g0), 32'd0);
    check_val({tag, "_adv0"},   32'(a0), 32'd0);
    check_val({tag, "_blank1"}, 32'(b1), 32'd1);
    check_val({tag, "_grant1"}, 32'(g1), 32'd0);
  endtask

  initial begin
    int n;
    src_req = 4'd0;
    src_x   = $urandom;
    src_y   = $urandom;
    #1 rst_n = 1'b0;
    #1 check_parked("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    src_req = 4'b0010;
    repeat (20) tick();

    src_req = 4'b1111;
    repeat (40) tick();

    src_req = 4'b1100;
    repeat (30) begin
      tick();
      if ($urandom_range(0, 5) == 0) src_req[2] = ~src_req[2];
    end

    repeat (300) begin
      tick();
      if ($urandom_range(0, 5) == 0) src_req = 4'($urandom);
    end

    src_req = 4'b0000;
    repeat (10) tick();
    src_req = 4'b0001;
    repeat (10) tick();

    src_req = 4'b0011;
    repeat (40) tick();

    src_req = 4'b1111;
    n = 0;
    while (m_phase[0] != 2 && n < 50) begin
      tick();
      n++;
    end
    tick();
    check_val("mid_draw_blank", 32'(b0), 32'd0);
    #2 rst_n = 1'b0;
    #1 check_parked("mid_rst");
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    repeat (30) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
